// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared port ids, stage-1 pipeline record and ROM address check
//   PORT_FETCH / PORT_LOAD : requester ids (0 = instruction fetch, 1 = data load)
//   s1_t                   : owner / valid / bad flags registered at the end of the grant cycle
//   addr_bad()             : misaligned or beyond the last ROM word
package rom_arb_pkg;

   localparam logic PORT_FETCH = 1'b0;
   localparam logic PORT_LOAD  = 1'b1;

   typedef struct packed {
      logic owner;
      logic valid;
      logic bad;
   } s1_t;

   // Addresses are zero-extended to 64 bits so one function serves any bus width up to 64.
   function automatic logic addr_bad(input logic [63:0] addr, input int depth);
      return (addr[1:0] != 2'b00) || (addr[63:2] >= 62'(depth));
   endfunction

endpackage

// File: rtl/rom_arb_picker.sv
// rom_arb_picker: 2-way priority picker, fixed or round-robin (ROM_ARB_RR_EN)
//   req_i  : requests, bit 0 = fetch, bit 1 = load
//   last_i : id of the previous winner (only consulted in round-robin builds)
//   gnt_o  : one-hot grant, zero when nothing requests
//   win_o  : winner id; 0 when nothing requests
module rom_arb_picker (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] gnt_o,
   output logic       win_o
);

`ifdef ROM_ARB_RR_EN
   // On a tie the port that did not win last time goes next.
   assign win_o = (req_i[0] & req_i[1]) ? ~last_i : req_i[1];
`else
   logic unused_last;
   assign unused_last = last_i;
   assign win_o = req_i[1] & ~req_i[0];
`endif

   assign gnt_o = {req_i[1] & win_o, req_i[0] & ~win_o};

endmodule

// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter: shares one synchronous ROM between fetch (port 0) and load (port 1)
//   mN_req_i/mN_addr_i         : requests, held until mN_gnt_o
//   mN_gnt_o                   : combinational grant, at most one per cycle
//   mN_rvalid_o/rdata_o/err_o  : registered response two cycles after the grant
//   rom_en_n_o/rom_addr_o      : ROM enable (active low) and byte address
//   rom_data_i                 : ROM read data, valid the cycle after an enabled edge
// Define ROM_ARB_RR_EN for round-robin tie breaking; fixed priority to port 0 otherwise.
module rom_access_arbiter
   import rom_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ROM_DEPTH  = 2048
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  m0_req_i,
   input  logic [ADDR_WIDTH-1:0] m0_addr_i,
   output logic                  m0_gnt_o,
   output logic                  m0_rvalid_o,
   output logic [DATA_WIDTH-1:0] m0_rdata_o,
   output logic                  m0_err_o,
   input  logic                  m1_req_i,
   input  logic [ADDR_WIDTH-1:0] m1_addr_i,
   output logic                  m1_gnt_o,
   output logic                  m1_rvalid_o,
   output logic [DATA_WIDTH-1:0] m1_rdata_o,
   output logic                  m1_err_o,
   output logic                  rom_en_n_o,
   output logic [ADDR_WIDTH-1:0] rom_addr_o,
   input  logic [DATA_WIDTH-1:0] rom_data_i
);

   logic [1:0]            req, gnt, rvalid_d, rvalid_q, err_d, err_q;
   logic                  win, last, grant, bad, good;
   logic [ADDR_WIDTH-1:0] win_addr, rom_addr_d, rom_addr_q;
   logic [DATA_WIDTH-1:0] rdata0_d, rdata0_q, rdata1_d, rdata1_q;
   s1_t                   s1_d, s1_q;

   // Reset masks requests so a grant can never coincide with reset.
   assign req = {m1_req_i, m0_req_i} & {2{reset_n}};

   rom_arb_picker u_picker (
      .req_i (req),
      .last_i(last),
      .gnt_o (gnt),
      .win_o (win)
   );

`ifdef ROM_ARB_RR_EN
   logic last_d, last_q;
   assign last_d = grant ? win : last_q;
   assign last   = last_q;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) last_q <= PORT_LOAD;
      else last_q <= last_d;
`else
   assign last = PORT_LOAD;
`endif

   always_comb begin
      grant      = |gnt;
      win_addr   = win ? m1_addr_i : m0_addr_i;
      bad        = addr_bad(64'(win_addr), ROM_DEPTH);
      good       = grant & ~bad;
      rom_addr_d = good ? win_addr : rom_addr_q;
      s1_d       = '{owner: win, valid: grant, bad: bad};
      rvalid_d   = {2{s1_q.valid}} & (2'b01 << s1_q.owner);
      err_d      = s1_q.bad ? rvalid_d : 2'b00;
      rdata0_d   = rvalid_d[PORT_FETCH] ? (s1_q.bad ? '0 : rom_data_i) : rdata0_q;
      rdata1_d   = rvalid_d[PORT_LOAD]  ? (s1_q.bad ? '0 : rom_data_i) : rdata1_q;
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         rom_addr_q <= '0;
         s1_q       <= '0;
         rvalid_q   <= '0;
         err_q      <= '0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         rom_addr_q <= rom_addr_d;
         s1_q       <= s1_d;
         rvalid_q   <= rvalid_d;
         err_q      <= err_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
      end

   assign m0_gnt_o    = gnt[PORT_FETCH];
   assign m1_gnt_o    = gnt[PORT_LOAD];
   assign rom_en_n_o  = ~good;
   assign rom_addr_o  = rom_addr_d;
   assign m0_rvalid_o = rvalid_q[PORT_FETCH];
   assign m1_rvalid_o = rvalid_q[PORT_LOAD];
   assign m0_err_o    = err_q[PORT_FETCH];
   assign m1_err_o    = err_q[PORT_LOAD];
   assign m0_rdata_o  = rdata0_q;
   assign m1_rdata_o  = rdata1_q;

endmodule
